// File: rtl/bp_vcache_mem_cmd_buffer.sv
// Victim-cache memory command buffer: in-order FIFO toward the network
// plus outstanding-command credit tracking.
module bp_vcache_mem_cmd_buffer #(
  parameter int mem_msg_width_p = 128,
  parameter int els_p           = 4,
  parameter int credits_p       = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [mem_msg_width_p-1:0] mem_cmd_i,
  input  logic                       mem_cmd_v_i,
  output logic                       mem_cmd_ready_o,
  output logic [mem_msg_width_p-1:0] mem_cmd_o,
  output logic                       mem_cmd_v_o,
  input  logic                       mem_cmd_ready_i,
  input  logic                       mem_resp_v_i,
  input  logic                       mem_resp_yumi_i,
  output logic                       credits_full_o,
  output logic                       credits_empty_o,
  output logic                       credit_err_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int occ_w = $clog2(els_p + 1);
  localparam int cnt_w = $clog2(credits_p + 1);

  logic [mem_msg_width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0] rptr_r, wptr_r;
  logic [occ_w-1:0] occ_r;
  logic [cnt_w-1:0] cnt_r;
  logic             err_r;
  logic             init_r;

  logic enq, deq, resp, resp_ok;

  assign enq     = mem_cmd_v_i & mem_cmd_ready_o;
  assign deq     = mem_cmd_v_o & mem_cmd_ready_i;
  assign resp    = mem_resp_v_i & mem_resp_yumi_i;
  assign resp_ok = resp & (cnt_r != '0);

  // init_r keeps ready low for the first cycle after reset release
  assign mem_cmd_ready_o = init_r
                         & (occ_r < occ_w'(els_p))
                         & (cnt_r < cnt_w'(credits_p));
  assign mem_cmd_v_o     = (occ_r != '0);
  assign mem_cmd_o       = mem_r[rptr_r];
  assign credits_full_o  = (cnt_r == cnt_w'(credits_p));
  assign credits_empty_o = (cnt_r == '0);
  assign credit_err_o    = err_r;

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= mem_cmd_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      occ_r  <= '0;
      cnt_r  <= '0;
      err_r  <= 1'b0;
      init_r <= 1'b0;
    end else begin
      init_r <= 1'b1;
      if (enq) wptr_r <= wptr_r + ptr_w'(1);
      if (deq) rptr_r <= rptr_r + ptr_w'(1);
      unique case ({enq, deq})
        2'b10:   occ_r <= occ_r + occ_w'(1);
        2'b01:   occ_r <= occ_r - occ_w'(1);
        default: occ_r <= occ_r;
      endcase
      cnt_r <= cnt_r + cnt_w'(enq) - cnt_w'(resp_ok);
      if (resp & ~resp_ok) err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_vcache_mem_cmd_buffer.sv
// Self-checking bench: directed phases plus random traffic against a
// queue-based reference model.
module tb_bp_vcache_mem_cmd_buffer;

  localparam int W  = 128;
  localparam int E  = 4;
  localparam int CR = 8;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic [W-1:0] mem_cmd_i = '0;
  logic         mem_cmd_v_i = 1'b0;
  logic         mem_cmd_ready_o;
  logic [W-1:0] mem_cmd_o;
  logic         mem_cmd_v_o;
  logic         mem_cmd_ready_i = 1'b0;
  logic         mem_resp_v_i = 1'b0;
  logic         mem_resp_yumi_i = 1'b0;
  logic         credits_full_o;
  logic         credits_empty_o;
  logic         credit_err_o;

  bp_vcache_mem_cmd_buffer #(
    .mem_msg_width_p(W), .els_p(E), .credits_p(CR)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .mem_cmd_i(mem_cmd_i),
    .mem_cmd_v_i(mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_cmd_o(mem_cmd_o),
    .mem_cmd_v_o(mem_cmd_v_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_v_i(mem_resp_v_i),
    .mem_resp_yumi_i(mem_resp_yumi_i),
    .credits_full_o(credits_full_o),
    .credits_empty_o(credits_empty_o),
    .credit_err_o(credit_err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q[$];
  int           outst;
  bit           err;
  bit           live;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return live && (q.size() < E) && (outst < CR);
  endfunction

  task automatic check_all();
    chk("v_o", W'(mem_cmd_v_o), W'(q.size() != 0));
    if (q.size() != 0) chk("cmd_o", mem_cmd_o, q[0]);
    chk("ready_o", W'(mem_cmd_ready_o), W'(m_ready()));
    chk("full", W'(credits_full_o), W'(outst == CR));
    chk("empty", W'(credits_empty_o), W'(outst == 0));
    chk("err", W'(credit_err_o), W'(err));
  endtask

  // one cycle, entered and left just after a negedge
  task automatic cyc(input logic [W-1:0] c, input bit v, input bit r,
                     input bit rv, input bit ry);
    bit enq, deq, rsp;
    mem_cmd_i       = c;
    mem_cmd_v_i     = v;
    mem_cmd_ready_i = r;
    mem_resp_v_i    = rv;
    mem_resp_yumi_i = ry;
    #1 check_all();
    enq = v && m_ready();
    deq = (q.size() != 0) && r;
    rsp = rv && ry;
    @(posedge clk_i);
    if (deq) void'(q.pop_front());
    if (enq) q.push_back(c);
    if (rsp) begin
      if (outst == 0) err = 1;
      else outst--;
    end
    if (enq) outst++;
    live = 1;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    #2 reset_i = 1'b1;
    #1;
    chk("rst_v_o", W'(mem_cmd_v_o), W'(0));
    chk("rst_ready", W'(mem_cmd_ready_o), W'(0));
    chk("rst_full", W'(credits_full_o), W'(0));
    chk("rst_empty", W'(credits_empty_o), W'(1));
    chk("rst_err", W'(credit_err_o), W'(0));
    q.delete();
    outst = 0;
    err = 0;
    live = 0;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [W-1:0] v8;
    do_reset();

    // fill with no drain, then drain in order
    cyc('0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      v8 = W'(i * 8'h11);
      cyc(v8, 1, 0, 0, 0);
    end
    chk("fill_ready", W'(mem_cmd_ready_o), W'(0));
    chk("fill_head", mem_cmd_o, W'(8'h11));
    for (int i = 0; i < 5; i++) cyc('0, 0, 1, 0, 0);
    chk("drained", W'(mem_cmd_v_o), W'(0));

    // mid-operation reset with 2 queued
    do_reset();
    cyc('0, 0, 0, 0, 0);
    cyc(W'(8'hA1), 1, 0, 0, 0);
    cyc(W'(8'hA2), 1, 0, 0, 0);
    chk("pre_rst_v", W'(mem_cmd_v_o), W'(1));
    do_reset();
    cyc('0, 0, 1, 0, 0);
    cyc('0, 0, 1, 0, 0);

    // streaming 16 commands through with wrap
    do_reset();
    cyc('0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(W'(32'h100 + i), 1, 1, 1, 1);
    end
    cyc('0, 0, 1, 0, 0);

    // credit limit with no responses
    do_reset();
    cyc('0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(rnd(), 1, 1, 0, 0);
    chk("lim_full", W'(credits_full_o), W'(1));
    chk("lim_ready", W'(mem_cmd_ready_o), W'(0));
    chk("lim_fifo", W'(mem_cmd_v_o), W'(0));
    cyc('0, 0, 1, 1, 1);
    chk("lim_release", W'(mem_cmd_ready_o), W'(1));
    chk("lim_notfull", W'(credits_full_o), W'(0));

    // simultaneous enqueue and response at outstanding 3
    do_reset();
    cyc('0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(rnd(), 1, 1, 0, 0);
    cyc(rnd(), 1, 1, 1, 1);
    cyc('0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc('0, 0, 1, 1, 1);
    chk("sim_empty", W'(credits_empty_o), W'(1));

    // underflow makes the error flag sticky until reset
    cyc('0, 0, 1, 1, 1);
    chk("uf_err", W'(credit_err_o), W'(1));
    chk("uf_empty", W'(credits_empty_o), W'(1));
    for (int i = 0; i < 3; i++) cyc('0, 0, 1, 0, 0);
    chk("uf_sticky", W'(credit_err_o), W'(1));
    do_reset();

    // random traffic
    cyc('0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      cyc(rnd(), bit'($urandom_range(0, 3) != 0),
          bit'($urandom_range(0, 2) != 0),
          bit'($urandom_range(0, 2) == 0),
          bit'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
